// File: rtl/instruction_fetch.sv
// ---------------------------------------------------------------------------
// instruction_fetch
//
// Fetch stage that sits directly in front of instruction decode. It holds the
// program counter, fetches one word at a time from instruction memory over a
// req/ack handshake, and presents that word to decode over a valid/ready
// handshake. When decode consumes an instruction, the next PC is either the
// sequential address or a branch target built from decode's immediate. If
// memory does not answer within MAX_WAIT cycles, a sticky error flag is set.
//
// Parameters:
//   RESET_PC  PC loaded on reset (word aligned)
//   MAX_WAIT  cycles of unanswered request before Fetch_Err sets (1..255)
//
// Ports:
//   Clk           rising-edge clock
//   Rst_n         asynchronous active-low reset
//   Imem_Addr     byte address of the requested word (bits [1:0] always 0)
//   Imem_Req      fetch request to instruction memory
//   Imem_Ack      memory returns Imem_Data this cycle
//   Imem_Data     instruction word, valid while Imem_Ack=1
//   Dec_Ready     decode consumes Instr this cycle
//   Branch_Taken  next PC is the branch target (sampled only on a consume)
//   Branch_Immed  sign-extended word-offset immediate from decode
//   Instr         instruction presented to decode
//   Instr_Valid   Instr holds a valid instruction
//   PC            address of the instruction in Instr / being fetched
//   Fetch_Err     sticky memory-timeout flag
// ---------------------------------------------------------------------------
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        Clk,
  input  logic        Rst_n,
  output logic [31:0] Imem_Addr,
  output logic        Imem_Req,
  input  logic        Imem_Ack,
  input  logic [31:0] Imem_Data,
  input  logic        Dec_Ready,
  input  logic        Branch_Taken,
  input  logic [31:0] Branch_Immed,
  output logic [31:0] Instr,
  output logic        Instr_Valid,
  output logic [31:0] PC,
  output logic        Fetch_Err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // The wait counter is 8 bits wide and saturates, so MAX_WAIT is compared
  // in the same width.
  localparam logic [7:0]  MAX_WAIT_C  = 8'(MAX_WAIT);
  localparam logic [31:0] RESET_PC_AL = {RESET_PC[31:2], 2'b00};

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        instr_valid_q, instr_valid_d;
  logic        fetch_err_q, fetch_err_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;

  logic [31:0] pc_plus4;
  logic [31:0] branch_off;
  logic [31:0] pc_next;

  // Next-PC datapath. The shift keeps 32 bits, so the top two immediate bits
  // fall off and the sum wraps modulo 2^32 like a plain two's complement add.
  always_comb begin
    pc_plus4   = pc_q + 32'd4;
    branch_off = Branch_Immed << 2;
    pc_next    = Branch_Taken ? (pc_plus4 + branch_off) : pc_plus4;
  end

  // Next-state and next-register logic for the whole stage. Inputs that do
  // not matter in the current state are simply never looked at there.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    fetch_err_d   = fetch_err_q;
    wait_cnt_d    = wait_cnt_q;

    case (state_q)
      IDLE: begin
        state_d = FETCH;
      end

      FETCH: begin
        if (Imem_Ack) begin
          instr_d       = Imem_Data;
          instr_valid_d = 1'b1;
          wait_cnt_d    = 8'd0;
          state_d       = HOLD;
        end else begin
          // Count unanswered cycles; the request stays up regardless.
          wait_cnt_d = (wait_cnt_q == 8'hFF) ? 8'hFF : (wait_cnt_q + 8'd1);
          if (wait_cnt_d >= MAX_WAIT_C) begin
            fetch_err_d = 1'b1;
          end
        end
      end

      HOLD: begin
        if (Dec_Ready) begin
          instr_valid_d = 1'b0;
          pc_d          = {pc_next[31:2], 2'b00};
          state_d       = FETCH;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register. Asynchronous reset aborts any fetch in flight, so an ack
  // that arrives while reset is asserted never reaches the datapath.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC_AL;
      instr_q       <= 32'd0;
      instr_valid_q <= 1'b0;
      fetch_err_q   <= 1'b0;
      wait_cnt_q    <= 8'd0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      fetch_err_q   <= fetch_err_d;
      wait_cnt_q    <= wait_cnt_d;
    end
  end

  // The request is decoded from state only, so it has no path from inputs
  // and drops together with the state register on reset.
  assign Imem_Req    = (state_q == FETCH);
  assign Imem_Addr   = pc_q;
  assign PC          = pc_q;
  assign Instr       = instr_q;
  assign Instr_Valid = instr_valid_q;
  assign Fetch_Err   = fetch_err_q;

endmodule
